ysyx_22040931_ifu: RTL and testbench
====================================

YSYX_22040931_IFU -- requirements
Module: ysyx_22040931_IFU

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, meaning the PC and memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 64, meaning the memory read data width; instruction width is fixed at 32.
REQ-003 The block SHALL have port clock  in  1  meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  in  1  meaning the reset: synchronous, active-low (0 = reset, sampled on rising edge of clock).
REQ-005 The block SHALL have port fetch_enb  in  1  meaning the PC stage permits a fetch of pc_i.
REQ-006 The block SHALL have port pc_i  in  ADDR_W  meaning the address to fetch.
REQ-007 The block SHALL have port flush  in  1  meaning redirect: discard any in-flight or held instruction.
REQ-008 The block SHALL have ports req_valid out 1, req_ready in 1, req_addr out ADDR_W, meaning the memory read request channel.
REQ-009 The block SHALL have ports resp_valid in 1, resp_data in DATA_W, resp_err in 1, meaning the memory read response channel; there is no resp_ready, and the response is accepted whenever presented.
REQ-010 The block SHALL have ports inst_valid out 1, inst_ready in 1, inst out 32, inst_pc out ADDR_W, inst_fault out 1, meaning the instruction output to decode.
REQ-011 The block SHALL have port fetch_done  out  1  meaning a one-cycle pulse equal to inst_valid & inst_ready, which tells the PC stage to advance.

Function
REQ-012 The block SHALL implement FSM states IDLE, REQ, WAIT, HOLD; reset state IDLE.
REQ-013 In IDLE, when fetch_enb=1 and flush=0, the block SHALL latch pc_i into pc_q.
- Transition: to HOLD with inst_fault=1, inst=0 if pc_i[1:0]!=0 (misaligned; no memory request).
- Otherwise transition to REQ.
REQ-014 In REQ, the block SHALL drive req_valid=1 and req_addr={pc_q[ADDR_W-1:3],3'b000}; on req_ready=1 it SHALL go to WAIT.
REQ-015 Once asserted, req_valid and req_addr SHALL stay stable until req_ready=1, including when flush is asserted.
REQ-016 Outside REQ, req_valid SHALL be 0.
REQ-017 In WAIT, on resp_valid=1 the block SHALL capture inst=pc_q[2] ? resp_data[63:32] : resp_data[31:0], inst_pc=pc_q, inst_fault=resp_err, and go to HOLD.
REQ-018 In HOLD, inst_valid SHALL be 1 with inst, inst_pc and inst_fault stable; on inst_ready=1 the block SHALL go to IDLE.
REQ-019 The minimum latency SHALL be: fetch_enb sampled at edge N -> req_valid from N+1; if req_ready in that same cycle and resp_valid one cycle later, inst_valid from N+3.
REQ-020 flush in IDLE or HOLD SHALL force IDLE next cycle, with inst_valid=0; a held instruction is discarded even if inst_ready=1 in the same cycle, and fetch_done=0.
REQ-021 flush in REQ or WAIT SHALL set drop_q=1; the request SHALL still complete, the matching response SHALL be discarded, and the FSM SHALL return to IDLE with drop_q cleared.
REQ-022 flush and resp_valid in the same WAIT cycle SHALL discard that response and go to IDLE.
REQ-023 resp_valid while in IDLE, REQ or HOLD SHALL be ignored.
REQ-024 At most one request SHALL be outstanding at any time.
REQ-025 fetch_enb deasserting while in REQ, WAIT or HOLD SHALL NOT abort the fetch.

Reset
REQ-026 While reset=0, the block SHALL go to IDLE and force req_valid=0, inst_valid=0, fetch_done=0, inst=0, inst_pc=0, inst_fault=0, drop_q=0, req_addr=0, from the first edge after assertion, regardless of prior state.
REQ-027 A response arriving after reset mid-WAIT SHALL be ignored per REQ-023.

Verification
REQ-028 Scenario: reset=0 for 2 cycles, then 1, fetch_enb=1, pc_i=0x80000000, req_ready=1, resp one cycle later with resp_data=0x0000007300000013 -> req_addr=0x80000000, inst=0x00000013, inst_pc=0x80000000, inst_valid at N+3.
REQ-029 Scenario: pc_i=0x80000004, same data -> req_addr=0x80000000, inst=0x00000073.
REQ-030 Scenario: req_ready held 0 for 3 cycles with flush pulsed in cycle 2 -> req_valid and req_addr stable for all 4 cycles; response discarded; inst_valid never 1; FSM returns to IDLE.
REQ-031 Scenario: inst_valid held with inst_ready=0 for 5 cycles -> inst stable and fetch_done=0 throughout; inst_ready=1 -> fetch_done=1 for exactly 1 cycle.
REQ-032 Scenario: pc_i=0x80000002 -> no req_valid; inst_valid=1, inst_fault=1, inst=0 on the second cycle.
REQ-033 Scenario: resp_err=1 -> inst_fault=1 alongside captured data.
REQ-034 Scenario: reset=0 asserted during WAIT, then resp_valid=1 -> all outputs 0, state IDLE, response ignored.

Source files
------------

// File: rtl/ysyx_22040931_ifu_if.sv
// Memory read channel and decode-side instruction channel used by the IFU.
// master = IFU side, slave = memory / decode side.
interface ysyx_22040931_mem_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport master (output req_valid, req_addr,
                  input  req_ready, resp_valid, resp_data, resp_err);
  modport slave  (input  req_valid, req_addr,
                  output req_ready, resp_valid, resp_data, resp_err);
endinterface

interface ysyx_22040931_inst_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_fault;

  modport master (output inst_valid, inst, inst_pc, inst_fault,
                  input  inst_ready);
  modport slave  (input  inst_valid, inst, inst_pc, inst_fault,
                  output inst_ready);
endinterface

// File: rtl/ysyx_22040931_ifu.sv
// Instruction fetch unit: one outstanding aligned read per fetch, selects the
// 32-bit word from the response and holds it until decode accepts it.
module ysyx_22040931_ifu #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fetch_enb,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic                flush,
  ysyx_22040931_mem_if.master mem,
  ysyx_22040931_inst_if.master dec,
  output logic                fetch_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [31:0]       r_inst, w_inst_nxt;
  logic [ADDR_W-1:0] r_inst_pc, w_inst_pc_nxt;
  logic              r_fault, w_fault_nxt;
  logic              r_drop, w_drop_nxt;
  logic [31:0]       w_inst_sel;
  logic              w_inst_valid;

  assign w_inst_sel = r_pc[2] ? mem.resp_data[DATA_W-1 -: 32] : mem.resp_data[31:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_inst_nxt    = r_inst;
    w_inst_pc_nxt = r_inst_pc;
    w_fault_nxt   = r_fault;
    w_drop_nxt    = r_drop;
    case (r_state)
      S_IDLE: begin
        w_drop_nxt = 1'b0;
        if (fetch_enb && !flush) begin
          w_pc_nxt = pc_i;
          // Misaligned PCs skip memory and present a faulting null instruction.
          if (pc_i[1:0] != 2'b00) begin
            w_state_nxt   = S_HOLD;
            w_inst_nxt    = '0;
            w_inst_pc_nxt = pc_i;
            w_fault_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush)         w_drop_nxt  = 1'b1;
        if (mem.req_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem.resp_valid) begin
          w_drop_nxt = 1'b0;
          if (r_drop || flush) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt   = S_HOLD;
            w_inst_nxt    = w_inst_sel;
            w_inst_pc_nxt = r_pc;
            w_fault_nxt   = mem.resp_err;
          end
        end else if (flush) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (flush || dec.inst_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_fault   <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_inst    <= w_inst_nxt;
      r_inst_pc <= w_inst_pc_nxt;
      r_fault   <= w_fault_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  // A flush in HOLD kills the handshake in the same cycle, so no fetch_done.
  assign w_inst_valid   = (r_state == S_HOLD) && !flush;
  assign mem.req_valid  = (r_state == S_REQ);
  assign mem.req_addr   = {r_pc[ADDR_W-1:3], 3'b000};
  assign dec.inst_valid = w_inst_valid;
  assign dec.inst       = r_inst;
  assign dec.inst_pc    = r_inst_pc;
  assign dec.inst_fault = r_fault;
  assign fetch_done     = w_inst_valid && dec.inst_ready;

endmodule

// File: tb/tb_ysyx_22040931_ifu.sv
// Scoreboard bench for the IFU: expected requests/instructions are queued by
// the directed stimulus and popped by a negedge monitor on each handshake.
module tb_ysyx_22040931_ifu;

  logic        clk;
  logic        rst_n;
  logic        fetch_enb;
  logic [63:0] pc_i;
  logic        flush;
  logic        fetch_done;

  ysyx_22040931_mem_if  #(.ADDR_W(64), .DATA_W(64)) mem ();
  ysyx_22040931_inst_if #(.ADDR_W(64))              dec ();

  ysyx_22040931_ifu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clock      (clk),
    .reset      (rst_n),
    .fetch_enb  (fetch_enb),
    .pc_i       (pc_i),
    .flush      (flush),
    .mem        (mem),
    .dec        (dec),
    .fetch_done (fetch_done)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic        fault;
  } exp_t;

  logic [63:0] exp_req[$];
  exp_t        exp_inst[$];
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mem.req_valid && mem.req_ready) begin
      if (exp_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_req: got addr %h expected none", mem.req_addr);
      end else begin
        chk("req_addr", mem.req_addr, exp_req.pop_front());
      end
    end
    if (dec.inst_valid && dec.inst_ready) begin
      if (exp_inst.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_inst: got inst %h pc %h expected none", dec.inst, dec.inst_pc);
      end else begin
        exp_t e;
        e = exp_inst.pop_front();
        chk("inst", {32'h0, dec.inst}, {32'h0, e.inst});
        chk("inst_pc", dec.inst_pc, e.pc);
        chk("inst_fault", {63'h0, dec.inst_fault}, {63'h0, e.fault});
        chk("fetch_done_hs", {63'h0, fetch_done}, 64'h1);
      end
    end
  end

  // Back-to-back minimum-latency fetch; inst_valid must appear at N+3.
  task automatic do_fetch(input logic [63:0] pc, input logic [63:0] data,
                          input logic err, input logic [31:0] ei);
    exp_req.push_back({pc[63:3], 3'b000});
    exp_inst.push_back('{ei, pc, err});
    fetch_enb = 1'b1; pc_i = pc; mem.req_ready = 1'b1; dec.inst_ready = 1'b1;
    tick();
    fetch_enb = 1'b0;
    @(negedge clk);
    chk("req_valid_n1", {63'h0, mem.req_valid}, 64'h1);
    tick();
    mem.resp_valid = 1'b1; mem.resp_data = data; mem.resp_err = err;
    @(negedge clk);
    chk("inst_valid_n2", {63'h0, dec.inst_valid}, 64'h0);
    tick();
    mem.resp_valid = 1'b0; mem.resp_err = 1'b0;
    @(negedge clk);
    chk("inst_valid_n3", {63'h0, dec.inst_valid}, 64'h1);
    tick();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req_valid"},  {63'h0, mem.req_valid},  64'h0);
    chk({tag, "_req_addr"},   mem.req_addr,            64'h0);
    chk({tag, "_inst_valid"}, {63'h0, dec.inst_valid}, 64'h0);
    chk({tag, "_inst"},       {32'h0, dec.inst},       64'h0);
    chk({tag, "_inst_pc"},    dec.inst_pc,             64'h0);
    chk({tag, "_inst_fault"}, {63'h0, dec.inst_fault}, 64'h0);
    chk({tag, "_fetch_done"}, {63'h0, fetch_done},     64'h0);
  endtask

  initial begin
    rst_n = 1'b0; fetch_enb = 1'b0; pc_i = '0; flush = 1'b0;
    mem.req_ready = 1'b0; mem.resp_valid = 1'b0; mem.resp_data = '0; mem.resp_err = 1'b0;
    dec.inst_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk_zero_outputs("reset");
    tick();
    rst_n = 1'b1;

    // Aligned fetches, low and high word, then an erroring response.
    do_fetch(64'h8000_0000, 64'h0000_0073_0000_0013, 1'b0, 32'h0000_0013);
    do_fetch(64'h8000_0004, 64'h0000_0073_0000_0013, 1'b0, 32'h0000_0073);
    do_fetch(64'h8000_0008, 64'hdead_beef_cafe_f00d, 1'b1, 32'hcafe_f00d);

    // Stalled request with flush in cycle 2: stable, then response dropped.
    exp_req.push_back(64'h8000_0010);
    fetch_enb = 1'b1; pc_i = 64'h8000_0014; mem.req_ready = 1'b0; dec.inst_ready = 1'b1;
    tick();
    fetch_enb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) flush = 1'b1;
      if (i == 3) mem.req_ready = 1'b1;
      @(negedge clk);
      chk("stall_req_valid", {63'h0, mem.req_valid}, 64'h1);
      chk("stall_req_addr", mem.req_addr, 64'h8000_0010);
      tick();
      flush = 1'b0;
    end
    mem.req_ready = 1'b0;
    mem.resp_valid = 1'b1; mem.resp_data = 64'h1111_2222_3333_4444;
    tick();
    mem.resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("drop_inst_valid", {63'h0, dec.inst_valid}, 64'h0);
      chk("drop_req_valid", {63'h0, mem.req_valid}, 64'h0);
      tick();
    end

    // Held instruction with decode stalled for 5 cycles.
    exp_req.push_back(64'h8000_0100);
    exp_inst.push_back('{32'haaaa_5555, 64'h8000_0104, 1'b0});
    fetch_enb = 1'b1; pc_i = 64'h8000_0104; mem.req_ready = 1'b1; dec.inst_ready = 1'b0;
    tick();
    fetch_enb = 1'b0;
    tick();
    mem.resp_valid = 1'b1; mem.resp_data = 64'haaaa_5555_1234_5678;
    tick();
    mem.resp_valid = 1'b0; mem.resp_data = 64'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {63'h0, dec.inst_valid}, 64'h1);
      chk("hold_inst", {32'h0, dec.inst}, 64'haaaa_5555);
      chk("hold_fetch_done", {63'h0, fetch_done}, 64'h0);
      tick();
    end
    dec.inst_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse", {63'h0, fetch_done}, 64'h1);
    tick();
    @(negedge clk);
    chk("done_after", {63'h0, fetch_done}, 64'h0);
    tick();

    // Misaligned PC: no request, faulting null instruction next cycle.
    exp_inst.push_back('{32'h0, 64'h8000_0002, 1'b1});
    fetch_enb = 1'b1; pc_i = 64'h8000_0002; dec.inst_ready = 1'b0;
    tick();
    fetch_enb = 1'b0;
    @(negedge clk);
    chk("mis_req_valid", {63'h0, mem.req_valid}, 64'h0);
    chk("mis_inst_valid", {63'h0, dec.inst_valid}, 64'h1);
    chk("mis_fault", {63'h0, dec.inst_fault}, 64'h1);
    chk("mis_inst", {32'h0, dec.inst}, 64'h0);
    tick();
    dec.inst_ready = 1'b1;
    @(negedge clk);
    tick();

    // Flush in HOLD together with inst_ready: instruction discarded.
    exp_req.push_back(64'h8000_0020);
    fetch_enb = 1'b1; pc_i = 64'h8000_0020; dec.inst_ready = 1'b0;
    tick();
    fetch_enb = 1'b0;
    tick();
    mem.resp_valid = 1'b1; mem.resp_data = 64'h0000_0000_0000_0093;
    tick();
    mem.resp_valid = 1'b0;
    flush = 1'b1; dec.inst_ready = 1'b1;
    @(negedge clk);
    chk("hflush_valid", {63'h0, dec.inst_valid}, 64'h0);
    chk("hflush_done", {63'h0, fetch_done}, 64'h0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("hflush_idle", {63'h0, dec.inst_valid}, 64'h0);
    tick();

    // Flush coinciding with the response in WAIT.
    exp_req.push_back(64'h8000_0028);
    fetch_enb = 1'b1; pc_i = 64'h8000_002c;
    tick();
    fetch_enb = 1'b0;
    tick();
    mem.resp_valid = 1'b1; mem.resp_data = 64'h5555_5555_6666_6666; flush = 1'b1;
    tick();
    mem.resp_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("wflush_valid", {63'h0, dec.inst_valid}, 64'h0);
    tick();

    // Flush with fetch_enb in IDLE starts nothing.
    fetch_enb = 1'b1; pc_i = 64'h8000_0030; flush = 1'b1;
    tick();
    fetch_enb = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("iflush_req_valid", {63'h0, mem.req_valid}, 64'h0);
    tick();

    // Reset during WAIT after a completed fetch left nonzero outputs.
    do_fetch(64'h8000_0044, 64'h0010_0073_0000_0000, 1'b0, 32'h0010_0073);
    exp_req.push_back(64'h8000_0200);
    fetch_enb = 1'b1; pc_i = 64'h8000_0204;
    tick();
    fetch_enb = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("wreset");
    tick();
    mem.resp_valid = 1'b1; mem.resp_data = 64'h7777_7777_8888_8888;
    tick();
    mem.resp_valid = 1'b0;
    @(negedge clk);
    chk_zero_outputs("post_reset");
    tick();

    // FSM must be back in IDLE and fully usable.
    do_fetch(64'h8000_0300, 64'h0000_0000_0000_0513, 1'b0, 32'h0000_0513);

    tick(); tick();
    chk("req_queue_empty", 64'(exp_req.size()), 64'h0);
    chk("inst_queue_empty", 64'(exp_inst.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
